pad_turbo: RTL
==============

# pad_turbo

Per-player autofire stage that sits directly upstream of the multitap and feeds its P1..P5 button inputs. It registers the five 12-button pad words. It passes direction, START and MODE straight through. On each of A, B, C, X, Y and Z it can replace a held button with a square wave timed in video frames. Frame timing comes from VBLANK rising edges, so the autofire rate is stable regardless of system clock.

## Interface
- NPLAYERS, 5, number of pads handled; pad word i occupies bits [12*i+11:12*i].
- CLK  in  1  system clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- JOY_IN  in  12*NPLAYERS  raw pad words, 1 = pressed; per-pad bit order [11:0] = {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}.
- TURBO_MASK  in  6*NPLAYERS  per-pad turbo enables; per-pad bit order [5:0] = {Z,Y,X,C,B,A}.
- TURBO_RATE  in  2  0: half-period 1 frame; 1: 2 frames; 2: 4 frames; 3: turbo globally off (pure pass-through).
- VBLANK  in  1  vertical blank, CLK domain; a rising edge is one frame tick.
- JOY_OUT  out  12*NPLAYERS  processed pad words, same bit order as JOY_IN; drives multitap P1..P5.

## Operation
- Frame tick: tick = VBLANK & ~vblank_d, where vblank_d is a 1-bit register.
- Half-period N is derived from TURBO_RATE: N = 1, 2 or 4.
- Pass-through bits (UP, DOWN, LEFT, RIGHT, START, MODE): JOY_OUT bit = JOY_IN bit, registered.
- Turbo buttons: 6*NPLAYERS independent cells. Each cell holds prev (1b), phase (1b, 1 = output on) and cnt (2b).
- Cell is bypassed (output = input, registered; phase=1, cnt=0) when its mask bit is 0 or TURBO_RATE==3.
- Cell is active when its mask bit is 1 and TURBO_RATE!=3. In an active cell, evaluated in priority order each cycle:
  1. Input 0 (released): output 0, phase=1, cnt=0.
  2. Input 1 and prev 0 (new press): output 1, phase=1, cnt=0. A tick in the same cycle is ignored for this cell.
  3. Input 1, held, tick: if cnt >= N-1, toggle phase, cnt=0, output = new phase. Otherwise cnt++, output unchanged.
  4. Input 1, held, no tick: hold all state.
- prev always loads the input bit.
- First ON period runs from the press until the N-th tick, so it is a partial frame plus N-1 frames. Later ON and OFF periods are exactly N frames each.
- Mask cleared while a button is held: the cell switches to bypass on the next cycle and the output goes to 1.
- Mask set while a button is held: the press is not re-detected. The cell starts at its reset phase (phase=1, cnt=0) and toggles on the N-th tick.
- TURBO_RATE change while held: the new N is used at the next tick. If cnt >= new N-1 at that tick, the phase toggles.
- Reset values: JOY_OUT = 0, all prev = 0, phase = 1, cnt = 0, vblank_d = 0.
- Reset mid-hold: after release of RESET the held input is treated as a new press.

## Timing
- Latency: JOY_IN to JOY_OUT is 1 CLK for every bit, in every mode.
- A tick affects outputs on the CLK following the VBLANK rising edge, since tick is seen in the cycle VBLANK is first high.
- No handshake. Inputs are sampled every cycle and there is no clock enable.
- Turbo frequencies at 60 Hz: rate 0 gives 30 Hz, rate 1 gives 15 Hz, rate 2 gives 7.5 Hz. At 50 Hz, scale proportionally.
- VBLANK high for many cycles produces exactly one tick.

## Structure
- Package pad_turbo_pkg holds:
  - pad bit-index constants (BTN_UP..BTN_Z);
  - turbo slot constants (TB_A..TB_Z) and the slot-to-pad-bit map;
  - the TURBO_RATE enum (RATE_1F, RATE_2F, RATE_4F, RATE_OFF);
  - NTURBO = 6.
- Sub-module pad_turbo_cell implements one turbo cell. Its ports are CLK, RESET, in, en, tick, half_n, out. The top generates NPLAYERS*NTURBO instances plus the pass-through registers and the tick detector.

## Test plan
- Reset → JOY_OUT = 0 while RESET is high. After release with JOY_IN = 0, JOY_OUT stays 0.
- Mask = 0 for all pads, P3 START and A pressed → JOY_OUT P3 bits go to 1 exactly one CLK later and follow the release one CLK later. No tick dependence.
- P1 A, mask bit A = 1, RATE = 0, held across 6 ticks → output 1 from press+1, then 0, 1, 0, 1, 0, 1 changing one CLK after each tick.
- RATE = 2, P5 Z held → output toggles only on every 4th tick. Switching to RATE = 1 when cnt = 3 → toggle at the next tick, then every 2nd tick.
- Press coinciding with a tick on the same CLK → output 1 with cnt = 0 (tick ignored for that cell). Release during the OFF phase → output 0. Re-press → output 1 immediately.
- Button held with output OFF, mask cleared → output 1 next CLK. RESET asserted mid-hold → output 0 asynchronously. After RESET release with the button still held → output 1 next CLK, behaving as a new press.

Source files
------------

// File: rtl/pad_turbo_pkg.sv
// rtl/pad_turbo_pkg.sv - pad bit layout, turbo slot map and rate encoding
package pad_turbo_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_MODE  = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_Y     = 10;
    localparam int BTN_Z     = 11;

    localparam int NTURBO = 6;
    localparam int TB_A   = 0;
    localparam int TB_B   = 1;
    localparam int TB_C   = 2;
    localparam int TB_X   = 3;
    localparam int TB_Y   = 4;
    localparam int TB_Z   = 5;

    // Bits that are never turbo-processed: directions, START, MODE
    localparam logic [11:0] PASS_BITS = 12'h18F;

    typedef enum logic [1:0] {
        RATE_1F  = 2'd0,
        RATE_2F  = 2'd1,
        RATE_4F  = 2'd2,
        RATE_OFF = 2'd3
    } turbo_rate_t;

    function automatic int turbo_bit(input int slot);
        case (slot)
            TB_A:    return BTN_A;
            TB_B:    return BTN_B;
            TB_C:    return BTN_C;
            TB_X:    return BTN_X;
            TB_Y:    return BTN_Y;
            default: return BTN_Z;
        endcase
    endfunction

endpackage

// File: rtl/pad_turbo_cell.sv
// rtl/pad_turbo_cell.sv - one autofire cell: press detect, frame counter, phase toggle
module pad_turbo_cell
    import pad_turbo_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       in,
    input  logic       en,
    input  logic       tick,
    input  logic [2:0] half_n,
    output logic       out
);

    logic       prev;
    logic       phase;
    logic [1:0] cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev  <= 1'b0;
            phase <= 1'b1;
            cnt   <= 2'd0;
            out   <= 1'b0;
        end else begin
            prev <= in;
            if (!en || !in || !prev) begin
                // bypass, release and new press all restart the ON phase
                out   <= in;
                phase <= 1'b1;
                cnt   <= 2'd0;
            end else if (tick) begin
                // rate may have shrunk since the last tick, hence >= rather than ==
                if ({1'b0, cnt} >= half_n - 3'd1) begin
                    phase <= ~phase;
                    cnt   <= 2'd0;
                    out   <= ~phase;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/pad_turbo.sv
// rtl/pad_turbo.sv - per-player autofire stage ahead of the multitap
module pad_turbo
    import pad_turbo_pkg::*;
#(
    parameter int NPLAYERS = 5
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [12*NPLAYERS-1:0]   JOY_IN,
    input  logic [6*NPLAYERS-1:0]    TURBO_MASK,
    input  logic [1:0]               TURBO_RATE,
    input  logic                     VBLANK,
    output logic [12*NPLAYERS-1:0]   JOY_OUT
);

    logic                          vblank_d;
    logic                          tick;
    logic                          turbo_on;
    logic [2:0]                    half_n;
    logic [12*NPLAYERS-1:0]        pass_q;
    logic [NTURBO*NPLAYERS-1:0]    cell_out;

    assign tick     = VBLANK & ~vblank_d;
    assign turbo_on = (turbo_rate_t'(TURBO_RATE) != RATE_OFF);

    always_comb begin
        case (turbo_rate_t'(TURBO_RATE))
            RATE_1F: half_n = 3'd1;
            RATE_2F: half_n = 3'd2;
            RATE_4F: half_n = 3'd4;
            default: half_n = 3'd1;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vblank_d <= 1'b0;
            pass_q   <= '0;
        end else begin
            vblank_d <= VBLANK;
            pass_q   <= JOY_IN & {NPLAYERS{PASS_BITS}};
        end
    end

    for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
        for (genvar s = 0; s < NTURBO; s++) begin : g_slot
            pad_turbo_cell u_cell (
                .CLK    (CLK),
                .RESET  (RESET),
                .in     (JOY_IN[12*p + turbo_bit(s)]),
                .en     (TURBO_MASK[NTURBO*p + s] & turbo_on),
                .tick   (tick),
                .half_n (half_n),
                .out    (cell_out[NTURBO*p + s])
            );
        end
    end

    always_comb begin
        JOY_OUT = pass_q;
        for (int p = 0; p < NPLAYERS; p++) begin
            for (int s = 0; s < NTURBO; s++) begin
                JOY_OUT[12*p + turbo_bit(s)] = cell_out[NTURBO*p + s];
            end
        end
    end

endmodule
